// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: runs sequential fetches ahead of decode,
// buffers returned words with their PCs and discards stale responses.
module fetch_prefetch_queue #(
  parameter int               NBITS    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [NBITS-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_en,
  input  logic                       flush,
  input  logic [NBITS-1:0]           jpc,
  input  logic                       mem_rdy,
  input  logic                       valid,
  input  logic [NBITS-1:0]           rdata,
  input  logic                       deq,
  output logic                       proc_req,
  output logic [NBITS-1:0]           pc2mem,
  output logic                       out_valid,
  output logic [NBITS-1:0]           ir,
  output logic [NBITS-1:0]           pc,
  output logic [NBITS-1:0]           npc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       stall,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [NBITS-1:0] r_pc_q [DEPTH];
  logic [NBITS-1:0] r_ir_q [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_inflight;
  logic [CW-1:0]    r_drop;
  logic [NBITS-1:0] r_req_pc;
  logic [NBITS-1:0] r_resp_pc;
  logic             r_err;

  logic [CW-1:0] w_live;
  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_acc;
  logic          w_rsp;
  logic          w_keep;
  logic          w_deq;

  // Stored entries plus live in-flight requests never exceed DEPTH,
  // so every kept response has a free slot waiting for it.
  assign w_live = r_inflight - r_drop;
  assign w_occ  = {1'b0, r_count} + {1'b0, w_live};
  assign w_req  = ~rst & pc_en & ~flush
                & (w_occ < DEPTH_W)
                & (r_inflight < DEPTH_C);
  assign w_acc  = w_req & mem_rdy;
  assign w_rsp  = valid & (r_inflight != '0);
  assign w_keep = w_rsp & (r_drop == '0);
  assign w_deq  = deq & (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i] <= '0;
        r_ir_q[i] <= '0;
      end
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_req_pc   <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_err      <= 1'b0;
    end else begin
      if (valid && (r_inflight == '0))
        r_err <= 1'b1;
      if (flush) begin
        r_count    <= '0;
        r_rd       <= r_wr;
        r_req_pc   <= jpc;
        r_resp_pc  <= jpc;
        r_drop     <= r_inflight - CW'(w_rsp);
        r_inflight <= r_inflight - CW'(w_rsp);
      end else begin
        r_inflight <= r_inflight + CW'(w_acc) - CW'(w_rsp);
        if (w_acc)
          r_req_pc <= r_req_pc + NBITS'(4);
        if (w_rsp && (r_drop != '0))
          r_drop <= r_drop - CW'(1);
        if (w_keep) begin
          r_pc_q[r_wr] <= r_resp_pc;
          r_ir_q[r_wr] <= rdata;
          r_wr         <= r_wr + PW'(1);
          r_resp_pc    <= r_resp_pc + NBITS'(4);
        end
        if (w_deq)
          r_rd <= r_rd + PW'(1);
        r_count <= r_count + CW'(w_keep) - CW'(w_deq);
      end
    end
  end

  assign proc_req  = w_req;
  assign pc2mem    = r_req_pc;
  assign out_valid = (r_count != '0);
  assign ir        = r_ir_q[r_rd];
  assign pc        = r_pc_q[r_rd];
  // Zero while empty so the head outputs all read 0 straight out of reset.
  assign npc       = out_valid ? (r_pc_q[r_rd] + NBITS'(4)) : '0;
  assign count     = r_count;
  assign stall     = ~out_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: vector table for fill/drain,
// hand sequences for throughput, redirects, protocol error and wrap.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_en, flush, mem_rdy, valid, deq;
  logic [31:0] jpc, rdata;
  logic        proc_req, out_valid, stall, err;
  logic [31:0] pc2mem, ir, pc, npc;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  fetch_prefetch_queue #(
    .NBITS(32), .DEPTH(4), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .flush(flush), .jpc(jpc),
    .mem_rdy(mem_rdy), .valid(valid), .rdata(rdata), .deq(deq),
    .proc_req(proc_req), .pc2mem(pc2mem), .out_valid(out_valid),
    .ir(ir), .pc(pc), .npc(npc), .count(count), .stall(stall),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, rdy, v;
    logic [31:0] rd;
    logic        dq;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [2:0]  e_cnt;
    logic [31:0] e_pc, e_ir;
  } vec_t;

  vec_t tv[11];

  logic        pv[8];
  logic [31:0] pa[8];
  int          lat = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] fw(input logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic vec_t mkv(
    input logic en, rdy, v, input logic [31:0] rd, input logic dq,
    input logic er, input logic [31:0] ea, input logic eo,
    input logic [2:0] ec, input logic [31:0] ep, ei);
    vec_t t;
    t.en = en; t.rdy = rdy; t.v = v; t.rd = rd; t.dq = dq;
    t.e_req = er; t.e_addr = ea; t.e_ov = eo; t.e_cnt = ec;
    t.e_pc = ep; t.e_ir = ei;
    return t;
  endfunction

  task automatic mem_clear();
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
  endtask

  task automatic mem_drive();
    valid = pv[lat-1];
    rdata = fw(pa[lat-1]);
  endtask

  task automatic mem_capture();
    for (int i = 7; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = proc_req & mem_rdy;
    pa[0] = pc2mem;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_en = 1'b1; flush = 1'b0; jpc = '0;
    mem_rdy = 1'b1; valid = 1'b0; rdata = '0; deq = 1'b0;
    mem_clear();
    #1;
    chk("rst count", 32'(count), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst stall", 32'(stall), 32'd1);
    chk("rst proc_req", 32'(proc_req), 32'd0);
    chk("rst pc2mem", pc2mem, 32'h100);
    chk("rst err", 32'(err), 32'd0);
    chk("rst ir", ir, 32'd0);
    chk("rst pc", pc, 32'd0);
    chk("rst npc", npc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] epc;
    logic        found;
    int          at;

    tv[0]  = mkv(1,1,0,32'h0,        0, 1,32'h100,0,0,32'h0,  32'h0);
    tv[1]  = mkv(1,1,1,32'h0000_0013,0, 1,32'h104,0,0,32'h0,  32'h0);
    tv[2]  = mkv(1,1,1,32'h0040_0093,0, 1,32'h108,1,1,32'h100,32'h0000_0013);
    tv[3]  = mkv(1,1,1,32'h0080_0113,0, 1,32'h10C,1,2,32'h100,32'h0000_0013);
    tv[4]  = mkv(1,1,1,32'h00C0_0193,0, 0,32'h110,1,3,32'h100,32'h0000_0013);
    tv[5]  = mkv(1,1,0,32'h0,        0, 0,32'h110,1,4,32'h100,32'h0000_0013);
    tv[6]  = mkv(1,1,0,32'h0,        1, 0,32'h110,1,4,32'h100,32'h0000_0013);
    tv[7]  = mkv(1,1,0,32'h0,        0, 1,32'h110,1,3,32'h104,32'h0040_0093);
    tv[8]  = mkv(1,1,1,32'h0100_0213,0, 0,32'h114,1,3,32'h104,32'h0040_0093);
    tv[9]  = mkv(1,1,0,32'h0,        1, 0,32'h114,1,4,32'h104,32'h0040_0093);
    tv[10] = mkv(0,1,0,32'h0,        0, 0,32'h114,1,3,32'h108,32'h0080_0113);

    #1;
    do_reset();

    // fill to DEPTH with a 1-cycle memory, then drain/refill
    for (int k = 0; k < 11; k++) begin
      pc_en = tv[k].en; mem_rdy = tv[k].rdy; valid = tv[k].v;
      rdata = tv[k].rd; deq = tv[k].dq;
      #1;
      chk($sformatf("v%0d proc_req", k), 32'(proc_req), 32'(tv[k].e_req));
      chk($sformatf("v%0d pc2mem", k), pc2mem, tv[k].e_addr);
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(tv[k].e_ov));
      chk($sformatf("v%0d stall", k), 32'(stall), 32'(!tv[k].e_ov));
      chk($sformatf("v%0d count", k), 32'(count), 32'(tv[k].e_cnt));
      if (tv[k].e_ov) begin
        chk($sformatf("v%0d pc", k), pc, tv[k].e_pc);
        chk($sformatf("v%0d npc", k), npc, tv[k].e_pc + 32'd4);
        chk($sformatf("v%0d ir", k), ir, tv[k].e_ir);
      end
      @(negedge clk);
    end

    // continuous dequeue from cycle 3
    do_reset();
    lat = 1;
    epc = 32'h100;
    for (int c = 0; c < 30; c++) begin
      deq = (c >= 3);
      mem_drive();
      #1;
      if (c >= 2) chk("tp out_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        chk("tp pc", pc, epc);
        chk("tp ir", ir, fw(epc));
      end
      chk("tp count<=4", 32'(count <= 3'd4), 32'd1);
      if (out_valid && deq) epc = epc + 32'd4;
      mem_capture();
      @(negedge clk);
    end
    deq = 1'b0;
    chk("tp final pc", epc, 32'h16C);

    // redirect with three requests outstanding
    do_reset();
    lat = 4;
    for (int c = 0; c < 3; c++) begin
      mem_drive(); #1; mem_capture(); @(negedge clk);
    end
    flush = 1'b1; jpc = 32'h2000;
    mem_drive(); #1;
    chk("fl3 proc_req in flush", 32'(proc_req), 32'd0);
    mem_capture(); @(negedge clk);
    flush = 1'b0;
    mem_drive(); #1;
    chk("fl3 pc2mem", pc2mem, 32'h2000);
    chk("fl3 count", 32'(count), 32'd0);
    chk("fl3 proc_req", 32'(proc_req), 32'd1);
    mem_capture(); @(negedge clk);
    found = 1'b0; at = -1;
    for (int c = 0; c < 20 && !found; c++) begin
      mem_drive(); #1;
      if (out_valid) begin
        found = 1'b1; at = c;
        chk("fl3 first pc", pc, 32'h2000);
        chk("fl3 first ir", ir, fw(32'h2000));
      end
      mem_capture(); @(negedge clk);
    end
    chk("fl3 entry seen", 32'(found), 32'd1);
    chk("fl3 entry cycle", 32'(at), 32'd4);
    chk("fl3 err", 32'(err), 32'd0);

    // flush together with valid and deq, two outstanding
    do_reset();
    #1; @(negedge clk);
    valid = 1'b1; rdata = 32'h11; #1; @(negedge clk);
    valid = 1'b0; #1;
    chk("fv count", 32'(count), 32'd1);
    @(negedge clk);
    flush = 1'b1; jpc = 32'h2000; valid = 1'b1; rdata = 32'h22; deq = 1'b1;
    #1;
    chk("fv proc_req in flush", 32'(proc_req), 32'd0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0; deq = 1'b0; mem_rdy = 1'b0; #1;
    chk("fv count", 32'(count), 32'd0);
    chk("fv out_valid", 32'(out_valid), 32'd0);
    chk("fv pc2mem", pc2mem, 32'h2000);
    chk("fv proc_req", 32'(proc_req), 32'd1);
    @(negedge clk);
    pc_en = 1'b0; valid = 1'b1; rdata = 32'h33; #1; @(negedge clk);
    valid = 1'b0; #1;
    chk("fv stale dropped", 32'(out_valid), 32'd0);
    chk("fv err clear", 32'(err), 32'd0);
    @(negedge clk);
    // unsolicited response
    valid = 1'b1; rdata = 32'h44; #1; @(negedge clk);
    valid = 1'b0; #1;
    chk("us err", 32'(err), 32'd1);
    chk("us count", 32'(count), 32'd0);
    @(negedge clk); #1;
    chk("us err sticky", 32'(err), 32'd1);
    @(negedge clk);

    // address wrap at the top of memory
    mem_clear();
    lat = 1;
    flush = 1'b1; jpc = 32'hFFFF_FFFC;
    mem_drive(); #1; mem_capture(); @(negedge clk);
    flush = 1'b0; pc_en = 1'b1; mem_rdy = 1'b1;
    mem_drive(); #1;
    chk("wr pc2mem top", pc2mem, 32'hFFFF_FFFC);
    mem_capture(); @(negedge clk);
    mem_drive(); #1;
    chk("wr pc2mem wrap", pc2mem, 32'h0);
    mem_capture(); @(negedge clk);
    pc_en = 1'b0; deq = 1'b1;
    mem_drive(); #1;
    chk("wr head ov", 32'(out_valid), 32'd1);
    chk("wr head pc", pc, 32'hFFFF_FFFC);
    chk("wr head npc", npc, 32'h0);
    chk("wr head ir", ir, fw(32'hFFFF_FFFC));
    mem_capture(); @(negedge clk);
    deq = 1'b0;
    mem_drive(); #1;
    chk("wr next pc", pc, 32'h0);
    chk("wr next npc", npc, 32'h4);
    chk("wr next ir", ir, fw(32'h0));
    mem_capture(); @(negedge clk);

    // reset clears the sticky error
    do_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
